// File: rtl/md_sched.sv
// HI/LO multiply/divide scheduler: fixed-latency mult/div with D-stage stall request.
// Define MD_MADD_EN to enable madd/maddu (md_op 7/8 and SPECIAL2 stall decode).
//
// state | meaning
// IDLE  | no operation in flight; accepts start, mthi/mtlo write directly
// RUN   | result held in pending regs, counter counting down to commit
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] ir_d,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stop_md
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        hi_n;
    logic [31:0]        lo_n;
    logic               commit;

    logic op_mul, op_div, op_mac, op_signed, op_mthi, op_mtlo, op_valid;

    always_comb begin
        op_mul    = 1'b0;
        op_div    = 1'b0;
        op_mac    = 1'b0;
        op_signed = 1'b0;
        op_mthi   = 1'b0;
        op_mtlo   = 1'b0;
        case (md_op)
            4'd1: begin op_mul = 1'b1; op_signed = 1'b1; end
            4'd2: op_mul = 1'b1;
            4'd3: begin op_div = 1'b1; op_signed = 1'b1; end
            4'd4: op_div = 1'b1;
            4'd5: op_mthi = 1'b1;
            4'd6: op_mtlo = 1'b1;
`ifdef MD_MADD_EN
            4'd7: begin op_mac = 1'b1; op_signed = 1'b1; end
            4'd8: op_mac = 1'b1;
`endif
            default: ;
        endcase
        op_valid = op_mul | op_div | op_mac | op_mthi | op_mtlo;
    end

    // A 64x64 product truncated to 64 bits of the extended operands is the
    // exact signed or unsigned 32x32 product.
    logic [63:0] a_ext, b_ext, prod, mac_sum;
    assign a_ext   = {{32{op_signed & src_a[31]}}, src_a};
    assign b_ext   = {{32{op_signed & src_b[31]}}, src_b};
    assign prod    = a_ext * b_ext;
    assign mac_sum = {hi, lo} + prod;

    // Divide on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN.
    logic        a_neg, b_neg, div_zero;
    logic [31:0] mag_a, mag_b, mag_b_safe, q_mag, r_mag, quot, rem;
    assign a_neg      = op_signed & src_a[31];
    assign b_neg      = op_signed & src_b[31];
    assign mag_a      = a_neg ? (~src_a + 32'd1) : src_a;
    assign mag_b      = b_neg ? (~src_b + 32'd1) : src_b;
    assign div_zero   = (src_b == 32'd0);
    assign mag_b_safe = div_zero ? 32'd1 : mag_b;
    assign q_mag      = mag_a / mag_b_safe;
    assign r_mag      = mag_a % mag_b_safe;
    assign quot       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem        = a_neg ? (~r_mag + 32'd1) : r_mag;

    logic [63:0] result_n;
    always_comb begin
        result_n = prod;
        if (op_div)
            result_n = {rem, quot};
        else if (op_mac)
            result_n = mac_sum;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            hi_n   <= '0;
            lo_n   <= '0;
            commit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op_mul || op_div || op_mac) begin
                            {hi_n, lo_n} <= result_n;
                            commit       <= !(op_div && div_zero);
                            cnt          <= op_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                            busy         <= 1'b1;
                            state        <= RUN;
                        end else if (op_mthi) begin
                            hi <= src_a;
                        end else if (op_mtlo) begin
                            lo <= src_a;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        if (commit) begin
                            hi <= hi_n;
                            lo <= lo_n;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [5:0] ir_op, ir_funct;
    logic       md_class;
    logic       unused_ir;
    assign ir_op     = ir_d[31:26];
    assign ir_funct  = ir_d[5:0];
    assign unused_ir = ^ir_d[25:6];

    always_comb begin
        md_class = 1'b0;
        if (ir_op == 6'b000000)
            md_class = (ir_funct[5:2] == 4'b0110) || (ir_funct[5:2] == 4'b0100);
`ifdef MD_MADD_EN
        else if (ir_op == 6'b011100)
            md_class = (ir_funct[5:1] == 5'b00000);
`endif
    end

    assign stop_md = md_class && (busy || (start && op_valid));

endmodule

// File: doc/md_sched.md
# md_sched

Multi-cycle multiply/divide scheduler for the five-stage MIPS pipeline. Accepts one HI/LO-class operation per issue from the E stage and runs it for a fixed latency. It owns the HI and LO registers. It raises a stall request to the D-stage hazard logic whenever a D-stage HI/LO-class instruction would collide with an operation in flight. It sits beside the ALU in E and feeds the pipeline's global stall OR.

## Interface
- MULT_CYCLES, 5: busy cycles for mult/multu/madd/maddu (≥1)
- DIV_CYCLES, 10: busy cycles for div/divu (≥1)

- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high; one clock; resets all state
- start  in  1  E-stage instruction is a valid HI/LO operation this cycle
- md_op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu; others = none
- src_a  in  32  forwarded rs value
- src_b  in  32  forwarded rt value
- ir_d  in  32  D-stage instruction word
- busy  out  1  operation in flight
- hi  out  32  HI register
- lo  out  32  LO register
- stop_md  out  1  stall request for the D stage

## Operation
- States: IDLE, RUN. A 4-bit-or-wider down-counter is sized for max(MULT_CYCLES, DIV_CYCLES).
- IDLE, with start and md_op in {mult, multu, div, divu, madd, maddu}:
  - Compute the result into pending registers: 64-bit {hi_n, lo_n}.
  - Load the counter with the latency. Go to RUN.
- IDLE, with start and mthi/mtlo: write src_a to hi/lo at that edge. busy stays 0.
- mult: signed 32×32→64. multu: unsigned. Result: hi = [63:32], lo = [31:0].
- div: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend. divu: unsigned.
- div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- Divide by zero (src_b = 0): hi and lo are left unchanged. The full DIV_CYCLES busy period still runs.
- RUN: the counter decrements each cycle. On the edge where the counter equals 1, hi/lo are loaded from pending and the state returns to IDLE.
- start while in RUN is ignored: no effect on state, pending, hi or lo. The stop_md output guarantees this does not occur legally.
- D-stage HI/LO classes are decoded from ir_d:
  - op 000000 with funct 011000–011011 (mult/multu/div/divu), 010000–010011 (mfhi, mthi, mflo, mtlo).
  - op 011100 with funct 000000/000001 (madd/maddu), only when MD_MADD_EN is defined.
- stop_md = md_class(ir_d) && (busy || (start && md_op ≠ none)). Combinational.

## Timing
- Reset values: busy 0, hi 0, lo 0, stop_md 0 (given ir_d non-MD), state IDLE, counter 0.
- Reset asserted mid-RUN: the operation is discarded and hi/lo are cleared immediately (asynchronous).
- busy rises the cycle after the start edge and stays high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
- New hi/lo are visible in the first cycle busy is low. An mfhi released from D reads the updated value.
- mthi/mtlo results are visible the cycle after the start edge.
- Back-to-back: a second operation may start in the first cycle busy is low.
- stop_md depends only on current inputs and state. There is no registered delay.

## Configuration
- MD_MADD_EN defined:
  - md_op 7/8 are honoured: {hi,lo} ← {hi,lo} + signed (7) or unsigned (8) product, mod 2^64.
  - The accumulate uses the hi/lo values at the start edge. The result is committed after MULT_CYCLES.
  - SPECIAL2 madd/maddu in ir_d is treated as HI/LO-class for stalling.
- MD_MADD_EN undefined:
  - md_op 7/8 are treated as none.
  - SPECIAL2 funct 000000/000001 in ir_d does not raise stop_md.

## Test plan
- Reset, then mult with src_a=0xFFFFFFFE (−2), src_b=3 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- divu with src_a=7, src_b=2 → busy 10 cycles; then lo=3, hi=1. Repeat with div src_a=0xFFFFFFF9 (−7), src_b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div with src_b=0 after mthi 0x1234 / mtlo 0x5678 → busy 10 cycles; hi=0x1234, lo=0x5678 unchanged.
- During a mult, ir_d=mflo (0x00000012) → stop_md=1 every busy cycle, and 0 once busy falls. ir_d=addu (0x00000021) → stop_md=0 throughout.
- Reset pulsed in the 3rd busy cycle of a div → busy=0 and hi=lo=0 immediately. The next mult completes normally.
- With MD_MADD_EN, after hi=0, lo=0xFFFFFFFF, maddu with src_a=1, src_b=1 → hi=1, lo=0 after 5 cycles. Without the macro, md_op=8 → busy stays 0 and hi/lo are unchanged.
